// File: rtl/tx_line_serializer.sv
// tx_line_serializer
//
// Purpose:
//   Pulls packet bytes from the TX FIFO and serializes them onto the USB
//   D+/D- pair. Each packet is SYNC (8'h80, LSB first), then the data bytes
//   LSB first, with a stuffed 0 inserted after STUFF_LIMIT consecutive 1s.
//   Every transmitted bit, stuffed or not, is NRZI encoded. The packet ends
//   with two bit periods of SE0 followed by one bit period of J.
//
// Ports:
//   clk            system clock, everything on the rising edge
//   rst            synchronous active-high reset, aborts any packet
//   tx_start       one-cycle send request, honoured only while idle
//   tx_byte_count  bytes to send (1..64), a value of 0 is sent as 1
//   fifo_data      byte at the FIFO head
//   empty          FIFO empty flag, looked at only when loading a byte
//   tx_deq_word    one-cycle pulse, head byte consumed
//   d_plus/d_minus line levels (J = 1/0, K = 0/1, SE0 = 0/0)
//   tx_busy        high from the accepted start until the done cycle ends
//   tx_done        one-cycle pulse when the packet is complete
//   tx_error       one-cycle pulse when the FIFO underruns mid-packet

module tx_line_serializer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [6:0] tx_byte_count,
    input  logic [7:0] fifo_data,
    input  logic       empty,
    output logic       tx_deq_word,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int                ONES_W       = $clog2(STUFF_LIMIT + 1);
    localparam logic [7:0]        TIMER_LAST   = 8'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0] ONES_LIMIT   = ONES_W'(STUFF_LIMIT);
    localparam logic [7:0]        SYNC_PATTERN = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LOAD,
        DATA,
        STUFF,
        EOP,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [7:0]        timer, timer_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [7:0]        shreg, shreg_n;
    logic [6:0]        remaining, remaining_n;
    logic [ONES_W-1:0] ones, ones_n;
    logic [1:0]        eop_idx, eop_idx_n;
    logic              in_sync, in_sync_n;
    logic              dp, dp_n;
    logic              dm, dm_n;

    logic              wrap;
    logic              advance;
    logic              tx_en;
    logic              tx_bit;

    assign wrap    = (timer == TIMER_LAST);
    assign d_plus  = dp;
    assign d_minus = dm;

    // State and datapath registers. Reset forces the line back to J and
    // drops the packet on the spot; no done or error pulse follows because
    // those are decoded from the state, which returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            remaining <= '0;
            ones      <= '0;
            eop_idx   <= '0;
            in_sync   <= 1'b0;
            dp        <= 1'b1;
            dm        <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            remaining <= remaining_n;
            ones      <= ones_n;
            eop_idx   <= eop_idx_n;
            in_sync   <= in_sync_n;
            dp        <= dp_n;
            dm        <= dm_n;
        end
    end

    // Next-state and output logic.
    // SYNC is handled as an ordinary byte held in the shift register, so the
    // same end-of-period code walks SYNC and DATA bits and decides what comes
    // after a STUFF period (in_sync tells which state to resume).
    // The first data bit of a byte only becomes known in LOAD, so it reaches
    // the line on the edge that leaves LOAD; the LOAD cycle is cycle 0 of that
    // bit period and the period still ends on the regular boundary.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        remaining_n = remaining;
        ones_n      = ones;
        eop_idx_n   = eop_idx;
        in_sync_n   = in_sync;
        dp_n        = dp;
        dm_n        = dm;
        advance     = 1'b0;
        tx_en       = 1'b0;
        tx_bit      = 1'b0;
        tx_deq_word = 1'b0;
        tx_error    = 1'b0;
        tx_busy     = (state != IDLE);
        tx_done     = (state == DONE);

        if (state == IDLE || state == DONE || wrap) begin
            timer_n = '0;
        end else begin
            timer_n = timer + 8'd1;
        end

        case (state)
            IDLE: begin
                dp_n = 1'b1;
                dm_n = 1'b0;
                if (tx_start) begin
                    state_n     = SYNC;
                    remaining_n = (tx_byte_count == 7'd0) ? 7'd1 : tx_byte_count;
                    shreg_n     = SYNC_PATTERN;
                    bit_idx_n   = '0;
                    in_sync_n   = 1'b1;
                    ones_n      = '0;
                    tx_en       = 1'b1;
                    tx_bit      = SYNC_PATTERN[0];
                end
            end

            SYNC, DATA: begin
                if (wrap) begin
                    if (ones == ONES_LIMIT) begin
                        state_n = STUFF;
                        tx_en   = 1'b1;
                        tx_bit  = 1'b0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            STUFF: begin
                if (wrap) begin
                    advance = 1'b1;
                end
            end

            LOAD: begin
                if (empty) begin
                    // Underrun: abandon the packet and close it with a full EOP.
                    tx_error  = 1'b1;
                    state_n   = EOP;
                    eop_idx_n = '0;
                    timer_n   = '0;
                    dp_n      = 1'b0;
                    dm_n      = 1'b0;
                end else begin
                    tx_deq_word = 1'b1;
                    shreg_n     = fifo_data;
                    remaining_n = remaining - 7'd1;
                    bit_idx_n   = '0;
                    in_sync_n   = 1'b0;
                    state_n     = DATA;
                    tx_en       = 1'b1;
                    tx_bit      = fifo_data[0];
                end
            end

            EOP: begin
                if (wrap) begin
                    if (eop_idx == 2'd2) begin
                        state_n = DONE;
                    end else if (eop_idx == 2'd1) begin
                        eop_idx_n = 2'd2;
                        dp_n      = 1'b1;
                        dm_n      = 1'b0;
                    end else begin
                        eop_idx_n = 2'd1;
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // End of a SYNC/DATA/STUFF period with no stuff due: next bit of the
        // current byte, a new byte, or the end of the packet.
        if (advance) begin
            if (bit_idx != 3'd7) begin
                bit_idx_n = bit_idx + 3'd1;
                shreg_n   = {1'b0, shreg[7:1]};
                state_n   = in_sync ? SYNC : DATA;
                tx_en     = 1'b1;
                tx_bit    = shreg[1];
            end else if (in_sync || remaining != 7'd0) begin
                state_n = LOAD;
            end else begin
                state_n   = EOP;
                eop_idx_n = '0;
                dp_n      = 1'b0;
                dm_n      = 1'b0;
            end
        end

        // NRZI: a 0 toggles J<->K, a 1 holds the line and extends the run
        // of ones that drives bit stuffing.
        if (tx_en) begin
            if (tx_bit) begin
                ones_n = ones + 1'b1;
            end else begin
                dp_n   = ~dp;
                dm_n   = ~dm;
                ones_n = '0;
            end
        end
    end

endmodule

// File: tb/tb_tx_line_serializer.sv
// tb_tx_line_serializer
//
// Purpose:
//   Drives tx_line_serializer with directed and random packets from a small
//   FIFO model and compares line levels per bit period, dequeue/error/done
//   timing and busy length against a bit-stream model of the packet.
//
// Ports: none (top-level bench).

module tb_tx_line_serializer;

    localparam int CPB = 8;
    localparam int LIM = 6;
    localparam int MAX_CYCLES = 4000;
    localparam logic [1:0] LV_J   = 2'b10;
    localparam logic [1:0] LV_K   = 2'b01;
    localparam logic [1:0] LV_SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [6:0] tx_byte_count = '0;
    logic [7:0] fifo_data;
    logic       empty;
    logic       tx_deq_word;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];
    logic [7:0] pkt [0:63];
    int         wr_cnt = 0;
    int         rd_ptr = 0;

    tx_line_serializer #(
        .CLKS_PER_BIT(CPB),
        .STUFF_LIMIT (LIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_byte_count(tx_byte_count),
        .fifo_data    (fifo_data),
        .empty        (empty),
        .tx_deq_word  (tx_deq_word),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error)
    );

    always #5 clk = ~clk;

    // FIFO model: the head advances on the edge that ends a dequeue cycle
    assign empty     = (rd_ptr >= wr_cnt);
    assign fifo_data = (rd_ptr < wr_cnt && rd_ptr < 256) ? mem[rd_ptr] : 8'hEE;

    always @(posedge clk) begin
        if (rst) rd_ptr <= 0;
        else if (tx_deq_word) rd_ptr <= rd_ptr + 1;
    end

    // Sends one packet and checks it against the model.
    // inject_at >= 0 raises a second tx_start at that cycle of the packet.
    task automatic run_packet(input string name, input int count, input int n_queued,
                              input int inject_at);
        int eff, n_sent, ones, len, periods, c, busy_cycles, done_cnt, err_cnt;
        int done_at, err_at, exp_busy, exp_done_at;
        bit underrun, finished, bitv;
        int bits[$];
        int byte_start[$];
        int deq_at[$];
        logic [1:0] exp_lvl[$];
        logic [1:0] obs[$];
        logic [1:0] lvl;

        for (int i = 0; i < n_queued; i++) mem[wr_cnt + i] = pkt[i];
        wr_cnt = wr_cnt + n_queued;

        eff      = (count == 0) ? 1 : count;
        n_sent   = (n_queued < eff) ? n_queued : eff;
        underrun = (n_queued < eff);

        // transmitted bit stream: SYNC then bytes LSB first, stuffing applied
        ones = 0;
        for (int j = 0; j < 8 + 8 * n_sent; j++) begin
            if (j < 8) bitv = (j == 7);
            else bitv = pkt[(j - 8) / 8][(j - 8) % 8];
            if (j >= 8 && (j - 8) % 8 == 0) byte_start.push_back(bits.size());
            bits.push_back(int'(bitv));
            ones = bitv ? ones + 1 : 0;
            if (ones == LIM) begin
                bits.push_back(0);
                ones = 0;
            end
        end
        len     = bits.size();
        periods = len + 3;
        lvl = LV_J;
        foreach (bits[k]) begin
            if (bits[k] == 0) lvl = (lvl == LV_J) ? LV_K : LV_J;
            exp_lvl.push_back(lvl);
        end
        exp_lvl.push_back(LV_SE0);
        exp_lvl.push_back(LV_SE0);
        exp_lvl.push_back(LV_J);
        exp_done_at = CPB * periods + (underrun ? 1 : 0);
        exp_busy    = exp_done_at + 1;

        tx_byte_count = count[6:0];
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;

        checks++;
        if ({d_plus, d_minus} !== LV_K || tx_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s first_cycle: line=%b busy=%b, expected line=%b busy=1",
                     name, {d_plus, d_minus}, tx_busy, LV_K);
        end

        c = 0; busy_cycles = 0; done_cnt = 0; err_cnt = 0;
        done_at = -1; err_at = -1; finished = 0;
        while (c < MAX_CYCLES) begin
            if (tx_busy) busy_cycles++;
            if (tx_deq_word) deq_at.push_back(c);
            if (tx_done) begin done_cnt++; done_at = c; end
            if (tx_error) begin err_cnt++; err_at = c; end
            if (c % CPB == CPB / 2 && c / CPB < periods) obs.push_back({d_plus, d_minus});
            if (!tx_busy) begin
                finished = 1;
                break;
            end
            if (c == inject_at) begin
                tx_start = 1'b1;
                tx_byte_count = 7'd9;
            end
            if (c == inject_at + 1) tx_start = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        tx_start = 1'b0;

        checks++;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL %s timeout: busy still %b after %0d cycles, expected low",
                     name, tx_busy, c);
        end
        checks++;
        if (busy_cycles != exp_busy) begin
            errors++;
            $display("[TB] FAIL %s busy_len: got %0d expected %0d", name, busy_cycles, exp_busy);
        end
        checks++;
        if (deq_at.size() != n_sent) begin
            errors++;
            $display("[TB] FAIL %s deq_count: got %0d expected %0d", name, deq_at.size(), n_sent);
        end else begin
            foreach (deq_at[i]) begin
                checks++;
                if (deq_at[i] != CPB * byte_start[i]) begin
                    errors++;
                    $display("[TB] FAIL %s deq_time[%0d]: got cycle %0d expected %0d",
                             name, i, deq_at[i], CPB * byte_start[i]);
                end
            end
        end
        checks++;
        if (err_cnt != (underrun ? 1 : 0) || (underrun && err_at != CPB * len)) begin
            errors++;
            $display("[TB] FAIL %s error_pulse: got %0d at %0d expected %0d at %0d",
                     name, err_cnt, err_at, underrun ? 1 : 0, CPB * len);
        end
        checks++;
        if (done_cnt != 1 || done_at != exp_done_at) begin
            errors++;
            $display("[TB] FAIL %s done_pulse: got %0d at %0d expected 1 at %0d",
                     name, done_cnt, done_at, exp_done_at);
        end
        checks++;
        if (obs.size() != periods) begin
            errors++;
            $display("[TB] FAIL %s period_count: got %0d expected %0d", name, obs.size(), periods);
        end else begin
            foreach (obs[k]) begin
                checks++;
                if (obs[k] !== exp_lvl[k]) begin
                    errors++;
                    $display("[TB] FAIL %s line[%0d]: got %b expected %b",
                             name, k, obs[k], exp_lvl[k]);
                end
            end
        end
        checks++;
        if ({d_plus, d_minus} !== LV_J) begin
            errors++;
            $display("[TB] FAIL %s idle_line: got %b expected %b", name, {d_plus, d_minus}, LV_J);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wr_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({d_plus, d_minus} !== LV_J || tx_busy !== 1'b0 || tx_deq_word !== 1'b0 ||
            tx_done !== 1'b0 || tx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: line=%b busy=%b deq=%b done=%b err=%b, expected 10 0 0 0 0",
                     {d_plus, d_minus}, tx_busy, tx_deq_word, tx_done, tx_error);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_data;
        pkt[0] = 8'($urandom);
        pkt[1] = 8'($urandom);
        for (int i = 0; i < 2; i++) mem[wr_cnt + i] = pkt[i];
        wr_cnt = wr_cnt + 2;
        tx_byte_count = 7'd2;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (75) @(posedge clk);
        #1;
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pre_busy: got %b expected 1", tx_busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) wr_cnt = 0;
            checks++;
            if ({d_plus, d_minus} !== LV_J || tx_busy !== 1'b0 || tx_deq_word !== 1'b0 ||
                tx_done !== 1'b0 || tx_error !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid_data[%0d]: line=%b busy=%b deq=%b done=%b err=%b, expected 10 0 0 0 0",
                         i, {d_plus, d_minus}, tx_busy, tx_deq_word, tx_done, tx_error);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({d_plus, d_minus} !== LV_J || tx_busy !== 1'b0 || tx_deq_word !== 1'b0 ||
                tx_done !== 1'b0 || tx_error !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_after[%0d]: line=%b busy=%b deq=%b done=%b err=%b, expected 10 0 0 0 0",
                         i, {d_plus, d_minus}, tx_busy, tx_deq_word, tx_done, tx_error);
            end
        end
    endtask

    task automatic test_single_zero;
        pkt[0] = 8'h00;
        run_packet("single_00", 1, 1, -1);
    endtask

    task automatic test_stuffing;
        pkt[0] = 8'hFF;
        run_packet("stuff_FF", 1, 1, -1);
    endtask

    task automatic test_multi_byte;
        pkt[0] = 8'hA5;
        pkt[1] = 8'h3C;
        pkt[2] = 8'h01;
        run_packet("multi_3", 3, 3, -1);
    endtask

    task automatic test_underrun;
        pkt[0] = 8'h5A;
        pkt[1] = 8'hC3;
        run_packet("underrun", 4, 2, -1);
    endtask

    task automatic test_start_while_busy;
        pkt[0] = 8'h96;
        pkt[1] = 8'h7F;
        run_packet("start_busy", 2, 2, 90);
    endtask

    task automatic test_zero_count;
        pkt[0] = 8'h3E;
        run_packet("count_0", 0, 1, -1);
    endtask

    task automatic test_random;
        int n;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                // bias some bytes towards long runs of ones to exercise stuffing
                pkt[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) | 8'hFC : 8'($urandom);
            end
            run_packet($sformatf("random_%0d", r), n, n, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_stuffing();
        test_multi_byte();
        test_underrun();
        test_start_while_busy();
        test_zero_count();
        test_random();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_line_serializer.md
Name: tx_line_serializer

Overview:
- Downstream consumer of the TX FIFO. Pulls bytes one at a time with a one-cycle dequeue pulse into the FIFO control stage.
- Serializes each packet onto the USB D+/D- pair: SYNC pattern, LSB-first data, bit stuffing, NRZI encoding, then EOP.
- Sits between the TX FIFO and the USB line drivers. Started by the protocol controller with a byte count.

Parameters:
CLKS_PER_BIT, 8, system clocks per line bit period; legal range 4..255
STUFF_LIMIT, 6, consecutive 1 data bits after which a stuffed 0 is inserted

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
tx_start  input  1  one-cycle request to send a packet; honoured only in IDLE
tx_byte_count  input  7  number of bytes to send (1..64), sampled with tx_start
fifo_data  input  8  byte at the FIFO head
empty  input  1  FIFO empty flag
tx_deq_word  output  1  one-cycle pulse: head byte consumed
d_plus  output  1  D+ line level
d_minus  output  1  D- line level
tx_busy  output  1  high from accepted tx_start until DONE exits
tx_done  output  1  one-cycle pulse at packet completion
tx_error  output  1  one-cycle pulse on FIFO underrun

Behaviour:
- Reset: one clock is synchronous and active-high; reset is synchronous (rst sampled on the rising edge of clk). All outputs go to their idle values: d_plus=1, d_minus=0 (J), tx_busy=0, tx_deq_word=0, tx_done=0, tx_error=0. Reset mid-packet aborts the packet immediately. Line returns to J on the next edge. No done or error pulse.
- Bit timer: counter 0..CLKS_PER_BIT-1, runs in every state except IDLE and DONE. A bit period ends when the counter wraps. Line outputs change only at period boundaries, or on the first cycle of SYNC.
- NRZI, applied to every transmitted bit including stuffed bits:
  - bit 0 toggles the line (J<->K);
  - bit 1 holds the line;
  - K is d_plus=0, d_minus=1.
- Stuff counter: counts consecutive transmitted 1s in SYNC and DATA. It clears on any 0, including a stuffed 0. When it reaches STUFF_LIMIT, the next period is a STUFF period driving 0, and the data bit is deferred.
- States:
  - IDLE: line J. On tx_start, latch tx_byte_count into the remaining counter and go to SYNC. tx_busy rises the next cycle. A count of 0 is treated as 1.
  - SYNC: transmits 8'h80 LSB-first (7 zeros, then a one) → KJKJKJKK. The first bit drives on the cycle after tx_start.
  - LOAD: one cycle, entered at the boundary after the last SYNC bit or after a byte's last bit when remaining>0.
    - If empty=0: latch fifo_data into the shift register, pulse tx_deq_word, decrement remaining, go to DATA.
    - If empty=1: pulse tx_error and go to EOP (underrun abort).
    - The LOAD cycle counts as cycle 0 of the first data bit period, so bit periods stay uniform.
  - DATA: shifts 8 bits LSB-first, with STUFF insertions as required. After bit 7, go to LOAD if remaining>0, else EOP.
    - A stuff pending after the final data bit is still transmitted before EOP.
  - EOP: two bit periods of SE0 (d_plus=0, d_minus=0), then one bit period of J.
  - DONE: one cycle. Pulse tx_done (also after an underrun abort), drop tx_busy, go to IDLE.
- tx_start in any state other than IDLE is ignored.
- tx_deq_word is never asserted twice within CLKS_PER_BIT cycles. The FIFO control stage needs ≥2 cycles to advance its head, so fifo_data is sampled at least 8*CLKS_PER_BIT cycles after the previous dequeue.
- empty is sampled only in LOAD. A FIFO going empty after the final byte is not an error.

Test Plan:
- Reset: hold rst 3 cycles mid-DATA → d_plus=1, d_minus=0, tx_busy=0 next cycle; no tx_deq_word, tx_done or tx_error pulse.
- Single byte: tx_start, tx_byte_count=1, fifo_data=8'h00, CLKS_PER_BIT=8.
  - Expect KJKJKJKK SYNC, then 8 toggles JKJKJKJK.
  - Expect SE0 for 16 cycles, then J for 8 cycles.
  - Expect exactly one tx_deq_word, one tx_done, and tx_busy high 8*(8+8+3)+1 cycles.
- Bit stuffing: 1 byte 8'hFF → SYNC's trailing 1 plus 5 data ones reach the limit. A stuffed K-toggle is inserted after data bit 4, and the total packet length grows by exactly one bit period.
- Multi-byte: tx_byte_count=3 with FIFO holding 8'hA5, 8'h3C, 8'h01 → three tx_deq_word pulses, 64 cycles apart; decoded NRZI stream equals SYNC+A5+3C+01 LSB-first.
- Underrun: tx_byte_count=4 with only 2 bytes queued (empty=1 at third LOAD) → tx_error pulse, immediate EOP, then tx_done; exactly 2 tx_deq_word pulses.
- Start while busy: second tx_start during DATA → ignored; the packet completes unchanged and a single tx_done is seen.
